scan_display_driver: RTL and testbench

//  Generic time-multiplexed driver for a common-anode 7-segment bank (active-low seg/an).

---
 rtl/display_pkg.sv | 26 ++
 rtl/refresh_prescaler.sv | 28 ++
 rtl/scan_display_driver.sv | 135 +++++++++++++
 tb/tb_scan_display_driver.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared 7-segment constants for the display path: active-low {a,b,c,d,e,f,g,dp} patterns
// and a BCD-to-segment helper used by the formatters that feed scan_display_driver.
package display_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] AN_NONE   = 8'hFF;

  localparam logic [7:0] SEG_DIGIT [0:9] = '{
    8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99,
    8'h49, 8'h41, 8'h1F, 8'h01, 8'h09
  };

  localparam logic [7:0] SEG_H = 8'h91;
  localparam logic [7:0] SEG_E = 8'h61;
  localparam logic [7:0] SEG_L = 8'hE3;
  localparam logic [7:0] SEG_O = 8'h03;
  localparam logic [7:0] SEG_F = 8'h71;
  localparam logic [7:0] SEG_I = 8'hF3;
  localparam logic [7:0] SEG_N = 8'hD5;

  // Non-decimal codes render as a blank digit rather than garbage segments.
  function automatic logic [7:0] seg_of_bcd(input logic [3:0] bcd);
    return (bcd <= 4'd9) ? SEG_DIGIT[bcd] : SEG_BLANK;
  endfunction

endpackage

// File: rtl/refresh_prescaler.sv
// Free-running divider producing a one-cycle clock-enable (tick) every DIV cycles;
// it never generates a derived clock.
module refresh_prescaler #(
  parameter int DIV = 16384
) (
  input  logic clock,
  input  logic reset_n,
  output logic tick
);

  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (r_count == LAST) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CW'(1);
    end
  end

  assign tick = (r_count == LAST);

endmodule

// File: rtl/scan_display_driver.sv
// Double-buffered time-multiplexed driver for a common-anode 7-segment bank (active-low pins).
// Optional blinking is compiled in with `define SCAN_DISPLAY_BLINK_EN.
module scan_display_driver
  import display_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int REFRESH_DIV  = 16384,
  parameter int BLINK_FRAMES = 32
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    load,
  input  logic [8*NUM_DIGITS-1:0] digit_data,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic [7:0]              seq,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int                    IDX_W    = $clog2(NUM_DIGITS);
  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_ONE   = NUM_DIGITS'(1);

  logic                    w_tick;
  logic                    w_boundary;
  logic [IDX_W-1:0]        r_idx;
  logic [8*NUM_DIGITS-1:0] r_act_data, r_pend_data;
  logic [NUM_DIGITS-1:0]   r_act_en, r_pend_en;
  logic [NUM_DIGITS-1:0]   r_act_blink, r_pend_blink;
  logic                    r_pend_valid;
  logic [NUM_DIGITS-1:0]   w_visible;
  logic [7:0]              w_digit [NUM_DIGITS];

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_unpack
      assign w_digit[gi] = r_act_data[8*gi +: 8];
    end
  endgenerate

  refresh_prescaler #(.DIV(REFRESH_DIV)) u_prescaler (
    .clock   (clock),
    .reset_n (reset_n),
    .tick    (w_tick)
  );

  assign w_boundary = w_tick && (r_idx == LAST_IDX);

  // Disabled digits still consume their slot so duty cycle is content-independent.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_idx <= '0;
    end else if (w_tick) begin
      r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_act_data   <= {NUM_DIGITS{SEG_BLANK}};
      r_act_en     <= '0;
      r_act_blink  <= '0;
      r_pend_data  <= {NUM_DIGITS{SEG_BLANK}};
      r_pend_en    <= '0;
      r_pend_blink <= '0;
      r_pend_valid <= 1'b0;
    end else if (load && w_boundary) begin
      // A load landing on the frame boundary skips the pending stage entirely.
      r_act_data   <= digit_data;
      r_act_en     <= digit_en;
      r_act_blink  <= blink_mask;
      r_pend_valid <= 1'b0;
    end else begin
      if (w_boundary && r_pend_valid) begin
        r_act_data   <= r_pend_data;
        r_act_en     <= r_pend_en;
        r_act_blink  <= r_pend_blink;
        r_pend_valid <= 1'b0;
      end
      if (load) begin
        r_pend_data  <= digit_data;
        r_pend_en    <= digit_en;
        r_pend_blink <= blink_mask;
        r_pend_valid <= 1'b1;
      end
    end
  end

`ifdef SCAN_DISPLAY_BLINK_EN
  localparam int               FRAME_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FRAME_W-1:0] LAST_FRAME = FRAME_W'(BLINK_FRAMES - 1);

  logic [FRAME_W-1:0] r_frame;
  logic               r_phase;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_frame <= '0;
      r_phase <= 1'b0;
    end else if (w_boundary) begin
      if (r_frame == LAST_FRAME) begin
        r_frame <= '0;
        r_phase <= ~r_phase;
      end else begin
        r_frame <= r_frame + FRAME_W'(1);
      end
    end
  end

  assign w_visible = r_act_en & ~(r_act_blink & {NUM_DIGITS{r_phase}});
`else
  logic w_unused_blink;
  assign w_unused_blink = ^{r_act_blink, 1'(BLINK_FRAMES)};
  assign w_visible      = r_act_en;
`endif

  // Pins follow r_idx one cycle late, so a new slot appears the cycle after its tick.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      seq        <= SEG_BLANK;
      an         <= AN_NONE[NUM_DIGITS-1:0];
      frame_done <= 1'b0;
    end else begin
      frame_done <= w_boundary;
      if (w_visible[r_idx]) begin
        seq <= w_digit[r_idx];
        an  <= ~(AN_ONE << r_idx);
      end else begin
        seq <= SEG_BLANK;
        an  <= AN_NONE[NUM_DIGITS-1:0];
      end
    end
  end

endmodule

// File: tb/tb_scan_display_driver.sv
// Directed bench for scan_display_driver with 3 digits, 4-cycle slots, 2-frame blink half-period.
module tb_scan_display_driver;

  logic        clock;
  logic        reset_n;
  logic        load;
  logic [23:0] digit_data;
  logic [2:0]  digit_en;
  logic [2:0]  blink_mask;
  logic [7:0]  seq;
  logic [2:0]  an;
  logic        frame_done;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [23:0] BLANK = 24'hFF_FF_FF;
  localparam logic [23:0] D1    = 24'h03_9F_25;
  localparam logic [23:0] D2    = 24'h91_61_E3;
  localparam logic [23:0] D3    = 24'h0D_99_49;

  scan_display_driver #(
    .NUM_DIGITS   (3),
    .REFRESH_DIV  (4),
    .BLINK_FRAMES (2)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .load       (load),
    .digit_data (digit_data),
    .digit_en   (digit_en),
    .blink_mask (blink_mask),
    .seq        (seq),
    .an         (an),
    .frame_done (frame_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // From reset release: 12 blank samples, frame_done only on the 12th.
  task automatic from_reset(input string tag);
    for (int i = 1; i <= 12; i++) begin
      step();
      check($sformatf("%s_an%0d", tag, i), 32'(an), 32'h7);
      check($sformatf("%s_seg%0d", tag, i), 32'(seq), 32'hFF);
      check($sformatf("%s_fd%0d", tag, i), 32'(frame_done), 32'(i == 12));
    end
    $display("[TB] %s: 12 cycles from reset checked", tag);
  endtask

  // One full frame starting right after a boundary; optional loads at sample la and lb.
  task automatic run_frame(input string tag, input logic [23:0] e_data, input logic [2:0] e_en,
                           input int la, input logic [23:0] da, input logic [2:0] ea,
                           input logic [2:0] ma,
                           input int lb, input logic [23:0] db, input logic [2:0] eb);
    int          d;
    logic [2:0]  exp_an;
    logic [7:0]  exp_seg;
    for (int s = 0; s < 12; s++) begin
      if (s == la) begin
        load = 1'b1; digit_data = da; digit_en = ea; blink_mask = ma;
      end else if (s == lb) begin
        load = 1'b1; digit_data = db; digit_en = eb; blink_mask = 3'b000;
      end
      step();
      load = 1'b0;
      d = s / 4;
      exp_an  = e_en[d] ? ~(3'b001 << d) : 3'b111;
      exp_seg = e_en[d] ? e_data[8*d +: 8] : 8'hFF;
      check($sformatf("%s_an%0d", tag, s), 32'(an), 32'(exp_an));
      check($sformatf("%s_seg%0d", tag, s), 32'(seq), 32'(exp_seg));
      check($sformatf("%s_fd%0d", tag, s), 32'(frame_done), 32'(s == 11));
    end
    $display("[TB] %s: frame data=%06h en=%03b checked", tag, e_data, e_en);
  endtask

  initial begin
    logic [2:0] blink_off;
    reset_n    = 1'b0;
    load       = 1'b0;
    digit_data = 24'h0;
    digit_en   = 3'b000;
    blink_mask = 3'b000;
    repeat (3) step();
    check("rst_seg", 32'(seq), 32'hFF);
    check("rst_an", 32'(an), 32'h7);
    check("rst_fd", 32'(frame_done), 32'h0);
    $display("[TB] reset state checked");
    @(negedge clock);
    reset_n = 1'b1;

    from_reset("t1_start");
    run_frame("t1_blank", BLANK, 3'b000, -1, 24'h0, 3'b000, 3'b000, -1, 24'h0, 3'b000);

    run_frame("t2_preload", BLANK, 3'b000, 4, D1, 3'b111, 3'b000, -1, 24'h0, 3'b000);
    run_frame("t2_show", D1, 3'b111, -1, 24'h0, 3'b000, 3'b000, -1, 24'h0, 3'b000);

    run_frame("t3_preload", D1, 3'b111, 1, D1, 3'b101, 3'b000, -1, 24'h0, 3'b000);
    run_frame("t3_show", D1, 3'b101, -1, 24'h0, 3'b000, 3'b000, -1, 24'h0, 3'b000);

    run_frame("t4_twoload", D1, 3'b101, 2, D2, 3'b111, 3'b000, 9, D3, 3'b111);
    run_frame("t4_show", D3, 3'b111, -1, 24'h0, 3'b000, 3'b000, -1, 24'h0, 3'b000);

    run_frame("t5_edgeload", D3, 3'b111, 11, D2, 3'b110, 3'b000, -1, 24'h0, 3'b000);
    run_frame("t5_show", D2, 3'b110, -1, 24'h0, 3'b000, 3'b000, -1, 24'h0, 3'b000);

    // Reset asserted between edges while digit 1 is on the pins.
    repeat (6) step();
    check("t6_pre_an", 32'(an), 32'h5);
    check("t6_pre_seg", 32'(seq), 32'h61);
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_async_seg", 32'(seq), 32'hFF);
    check("t6_async_an", 32'(an), 32'h7);
    check("t6_async_fd", 32'(frame_done), 32'h0);
    $display("[TB] t6: asynchronous reset mid-slot checked");
    @(negedge clock);
    reset_n = 1'b1;
    from_reset("t6_restart");

    run_frame("t7_preload", BLANK, 3'b000, 0, D1, 3'b111, 3'b010, -1, 24'h0, 3'b000);
`ifdef SCAN_DISPLAY_BLINK_EN
    blink_off = 3'b101;
`else
    blink_off = 3'b111;
`endif
    run_frame("t7_f2", D1, blink_off, -1, 24'h0, 3'b000, 3'b000, -1, 24'h0, 3'b000);
    run_frame("t7_f3", D1, blink_off, -1, 24'h0, 3'b000, 3'b000, -1, 24'h0, 3'b000);
    run_frame("t7_f4", D1, 3'b111, -1, 24'h0, 3'b000, 3'b000, -1, 24'h0, 3'b000);
    run_frame("t7_f5", D1, 3'b111, -1, 24'h0, 3'b000, 3'b000, -1, 24'h0, 3'b000);
    run_frame("t7_f6", D1, blink_off, -1, 24'h0, 3'b000, 3'b000, -1, 24'h0, 3'b000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
